// File: rtl/lpc_coeff_quantizer.sv
// Buffers ORDER IEEE-754 single LPC coefficients, picks a common quantizer shift
// and emits signed PRECISION-bit integer coefficients using integer-only arithmetic.
module lpc_coeff_quantizer #(
  parameter int unsigned ORDER     = 12,
  parameter int unsigned PRECISION = 15,
  parameter int unsigned MAX_SHIFT = 15,
  parameter bit          NEGATE    = 1'b1
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic                        iEnable,
  input  logic                        iStart,
  input  logic                        iValid,
  input  logic [31:0]                 iModel,
  output logic [4:0]                  oShift,
  output logic signed [PRECISION-1:0] oCoeff,
  output logic [3:0]                  oIndex,
  output logic                        oValid,
  output logic                        oOverflow,
  output logic                        oBusy,
  output logic                        oDone
);

  localparam int unsigned CW = $clog2(ORDER + 1);
  localparam logic [31:0] POS_MAX = (32'd1 << (PRECISION - 1)) - 32'd1;
  localparam logic [31:0] NEG_MAG = 32'd1 << (PRECISION - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [31:0]       buffer [ORDER];
  logic [ORDER-1:0]  inf_flag;
  logic [CW-1:0]     cnt;
  logic [7:0]        emax;

  // Common shift from the largest biased exponent seen during LOAD.
  logic signed [10:0] s_raw;
  logic [4:0]         s_next;

  always_comb begin
    s_raw  = $signed(11'(PRECISION + 125)) - $signed({3'b000, emax});
    s_next = '0;
    if (emax == 8'd0)
      s_next = '0;
    else if (s_raw < 11'sd0)
      s_next = '0;
    else if (s_raw > $signed(11'(MAX_SHIFT)))
      s_next = 5'(MAX_SHIFT);
    else
      s_next = s_raw[4:0];
  end

  // Quantization of the entry currently addressed by cnt during EMIT.
  logic [31:0]                 cur;
  logic                        cur_inf;
  logic [7:0]                  q_exp;
  logic [23:0]                 q_mant;
  logic                        q_neg;
  logic signed [10:0]          q_r;
  logic signed [10:0]          q_r_m1;
  logic signed [10:0]          q_l;
  logic [31:0]                 q_mag;
  logic                        q_sat;
  logic signed [PRECISION-1:0] q_val;

  assign cur     = buffer[cnt];
  assign cur_inf = inf_flag[cnt];

  always_comb begin
    q_exp  = cur[30:23];
    q_mant = {1'b1, cur[22:0]};
    q_neg  = cur[31] ^ NEGATE;
    q_r    = 11'sd150 - $signed({3'b000, q_exp}) - $signed({6'b000000, oShift});
    q_r_m1 = q_r - 11'sd1;
    q_l    = -q_r;
    q_mag  = '0;
    q_sat  = 1'b0;
    q_val  = '0;
    if (q_exp == 8'd0)
      q_mag = '0;
    else if (cur_inf)
      q_sat = 1'b1;
    else if (q_r >= 11'sd25)
      q_mag = '0;
    else if (q_r >= 11'sd1)
      q_mag = ({8'b0, q_mant} + (32'd1 << q_r_m1[4:0])) >> q_r[4:0];
    else if (q_r < -11'sd7)
      q_sat = 1'b1;
    else
      q_mag = {8'b0, q_mant} << q_l[2:0];

    // Negative side may reach one count further than the positive side.
    if (!q_sat)
      q_sat = q_neg ? (q_mag > NEG_MAG) : (q_mag > POS_MAX);

    if (q_sat)
      q_val = q_neg ? PRECISION'(NEG_MAG) : PRECISION'(POS_MAX);
    else if (q_neg)
      q_val = -q_mag[PRECISION-1:0];
    else
      q_val = q_mag[PRECISION-1:0];
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      emax      <= '0;
      inf_flag  <= '0;
      oShift    <= '0;
      oCoeff    <= '0;
      oIndex    <= '0;
      oValid    <= 1'b0;
      oOverflow <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
    end else if (iEnable) begin
      case (state)
        S_IDLE, S_DONE: begin
          oValid <= 1'b0;
          if (iStart) begin
            state     <= S_LOAD;
            cnt       <= '0;
            emax      <= '0;
            inf_flag  <= '0;
            oDone     <= 1'b0;
            oOverflow <= 1'b0;
            oBusy     <= 1'b1;
          end else if (state == S_DONE) begin
            oDone <= 1'b1;
          end
        end
        S_LOAD: begin
          if (iValid) begin
            buffer[cnt]   <= iModel;
            inf_flag[cnt] <= (iModel[30:23] == 8'hFF);
            if (iModel[30:23] != 8'd0 && iModel[30:23] > emax)
              emax <= iModel[30:23];
            cnt <= cnt + 1'b1;
            if (cnt == CW'(ORDER - 1))
              state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          oShift <= s_next;
          cnt    <= '0;
          state  <= S_EMIT;
        end
        S_EMIT: begin
          oValid <= 1'b1;
          oCoeff <= q_val;
          oIndex <= 4'(cnt + 1'b1);
          if (q_sat)
            oOverflow <= 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ORDER - 1)) begin
            state <= S_DONE;
            oBusy <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_coeff_quantizer.sv
// Directed and randomized checks of lpc_coeff_quantizer against a real-valued
// reference model; two instances cover both predictor sign conventions.
module tb_lpc_coeff_quantizer;

  localparam int P    = 15;
  localparam int MAXS = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        start;
  logic        valid;
  logic [31:0] model;

  logic [4:0]          shift_p, shift_n;
  logic signed [P-1:0] coeff_p, coeff_n;
  logic [3:0]          index_p, index_n;
  logic                valid_p, valid_n, ovf_p, ovf_n, busy_p, busy_n, done_p, done_n;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] vec [12];
  int          rbase;

  always #5 clk = ~clk;

  lpc_coeff_quantizer #(.ORDER(12), .PRECISION(P), .MAX_SHIFT(MAXS), .NEGATE(1'b0)) dut_pos (
    .iClock(clk), .iReset(rst_n), .iEnable(en), .iStart(start), .iValid(valid), .iModel(model),
    .oShift(shift_p), .oCoeff(coeff_p), .oIndex(index_p), .oValid(valid_p),
    .oOverflow(ovf_p), .oBusy(busy_p), .oDone(done_p)
  );

  lpc_coeff_quantizer #(.ORDER(12), .PRECISION(P), .MAX_SHIFT(MAXS), .NEGATE(1'b1)) dut_neg (
    .iClock(clk), .iReset(rst_n), .iEnable(en), .iStart(start), .iValid(valid), .iModel(model),
    .oShift(shift_n), .oCoeff(coeff_n), .oIndex(index_n), .oValid(valid_n),
    .oOverflow(ovf_n), .oBusy(busy_n), .oDone(done_n)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_shift_p"}, shift_p, 0);  check({tag, "_shift_n"}, shift_n, 0);
    check({tag, "_coeff_p"}, coeff_p, 0);  check({tag, "_coeff_n"}, coeff_n, 0);
    check({tag, "_index_p"}, index_p, 0);  check({tag, "_index_n"}, index_n, 0);
    check({tag, "_valid_p"}, valid_p, 0);  check({tag, "_valid_n"}, valid_n, 0);
    check({tag, "_ovf_p"},   ovf_p,   0);  check({tag, "_ovf_n"},   ovf_n,   0);
    check({tag, "_busy_p"},  busy_p,  0);  check({tag, "_busy_n"},  busy_n,  0);
    check({tag, "_done_p"},  done_p,  0);  check({tag, "_done_n"},  done_n,  0);
  endtask

  // Shift from the frexp exponent of the largest-magnitude nonzero coefficient.
  function automatic int ref_shift();
    int emax = 0;
    int s;
    for (int i = 0; i < 12; i++)
      if (int'(vec[i][30:23]) > emax) emax = int'(vec[i][30:23]);
    if (emax == 0) return 0;
    s = P - 1 - (emax - 126);
    if (s < 0) s = 0;
    if (s > MAXS) s = MAXS;
    return s;
  endfunction

  function automatic void ref_coeff(input logic [31:0] w, input int s, input bit neg,
                                    output int val, output bit ovf);
    int  ex;
    bit  sg;
    int  lp;
    int  ln;
    real mag;
    real rnd;
    ex  = int'(w[30:23]);
    sg  = w[31] ^ neg;
    lp  = (1 << (P - 1)) - 1;
    ln  = 1 << (P - 1);
    ovf = 1'b0;
    val = 0;
    if (ex == 0) begin
      val = 0;
    end else if (ex == 255) begin
      ovf = 1'b1;
      val = sg ? -ln : lp;
    end else begin
      mag = (1.0 + real'(int'(w[22:0])) / 8388608.0) * (2.0 ** real'(ex - 127 + s));
      rnd = $floor(mag + 0.5);
      if (!sg && rnd > real'(lp)) begin
        ovf = 1'b1; val = lp;
      end else if (sg && rnd > real'(ln)) begin
        ovf = 1'b1; val = -ln;
      end else begin
        val = sg ? -int'(rnd) : int'(rnd);
      end
    end
  endfunction

  function automatic logic [31:0] rand_word();
    int          k;
    logic [31:0] fr;
    logic        sg;
    int          ex;
    k  = $urandom_range(0, 31);
    fr = $urandom;
    sg = 1'($urandom_range(0, 1));
    if (k == 1) return {sg, 8'hFF, fr[22:0]};
    if (k <= 3) return {sg, 8'h00, fr[22:0]};
    ex = rbase + $urandom_range(0, 14);
    return {sg, 8'(ex), fr[22:0]};
  endfunction

  task automatic fill_random();
    rbase = $urandom_range(95, 140);
    for (int i = 0; i < 12; i++) vec[i] = rand_word();
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 12; i++) vec[i] = 32'h0;
  endtask

  // Entered and left on a negedge so a following run starts in the very first DONE cycle.
  task automatic run_model(input string tag, input bit toggle_en, input int abort_at);
    int  exp_s;
    int  ep [12];
    int  en_ [12];
    bit  ovp;
    bit  ovn;
    bit  o;
    int  accepted;
    int  guard;
    int  k;
    int  en_edges;
    int  cycles;
    bit  e;
    bit  aborted;
    logic                last_valid;
    logic signed [P-1:0] last_coeff;

    exp_s = ref_shift();
    ovp = 1'b0;
    ovn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ref_coeff(vec[i], exp_s, 1'b0, ep[i], o);  ovp |= o;
      ref_coeff(vec[i], exp_s, 1'b1, en_[i], o); ovn |= o;
    end

    en = 1'b1; start = 1'b1; valid = 1'b1; model = 32'h40490FDB;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy_p, 1);
    check({tag, "_done_cleared"}, done_p, 0);
    check({tag, "_ovf_cleared"}, ovf_n, 0);

    accepted = 0;
    guard = 0;
    while (accepted < 12 && guard < 200) begin
      e = toggle_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      en = e; valid = 1'b1; model = vec[accepted];
      start = toggle_en && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      if (e) accepted++;
      guard++;
    end
    valid = 1'b0; start = 1'b0; model = 32'hDEADBEEF;

    k = 0; en_edges = 0; cycles = 0; aborted = 1'b0;
    last_valid = valid_p; last_coeff = coeff_p;
    while (k < 12 && cycles < 300 && !aborted) begin
      e = toggle_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      en = e;
      @(negedge clk);
      cycles++;
      if (e) begin
        en_edges++;
        if (k == 0 && en_edges == 2) check({tag, "_latency"}, valid_p, 1);
        if (valid_p) begin
          if (k == 0) begin
            check({tag, "_shift_p"}, shift_p, exp_s);
            check({tag, "_shift_n"}, shift_n, exp_s);
          end
          check({tag, "_index"}, index_p, k + 1);
          check({tag, "_valid_n"}, valid_n, 1);
          check({tag, "_coeff_p"}, coeff_p, ep[k]);
          check({tag, "_coeff_n"}, coeff_n, en_[k]);
          k++;
        end else if (k > 0) begin
          check({tag, "_gap"}, valid_p, 1);
        end
      end else begin
        check({tag, "_hold_valid"}, valid_p, last_valid);
        check({tag, "_hold_coeff"}, coeff_p, last_coeff);
      end
      last_valid = valid_p;
      last_coeff = coeff_p;
      if (abort_at >= 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs({tag, "_abort"});
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        aborted = 1'b1;
      end
    end

    if (!aborted) begin
      check({tag, "_emit_count"}, k, 12);
      en = 1'b1;
      @(negedge clk);
      check({tag, "_valid_drop"}, valid_p, 0);
      check({tag, "_done_p"}, done_p, 1);
      check({tag, "_done_n"}, done_n, 1);
      check({tag, "_busy_done"}, busy_p, 0);
      check({tag, "_ovf_p"}, ovf_p, ovp);
      check({tag, "_ovf_n"}, ovf_n, ovn);
      check({tag, "_shift_hold"}, shift_p, exp_s);
    end
  endtask

  task automatic stray_idle(input string tag);
    en = 1'b1; valid = 1'b1; model = 32'h3F800000;
    repeat (3) @(negedge clk);
    valid = 1'b0;
    check({tag, "_busy"}, busy_p, 0);
    check({tag, "_valid"}, valid_p, 0);
    check({tag, "_done"}, done_n, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; valid = 1'b0; model = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    stray_idle("stray_idle");

    fill_zero();
    vec[0] = 32'h3FC00000; vec[1] = 32'hBE800000;
    run_model("t1_basic", 1'b0, -1);

    vec[1] = 32'h3F800200;
    run_model("t2_half_round", 1'b0, -1);

    fill_zero();
    run_model("t3_all_zero", 1'b0, -1);

    fill_zero();
    vec[0] = 32'h471C4000;
    run_model("t4_saturate", 1'b0, -1);
    vec[0] = 32'h7F800000;
    run_model("t4_inf", 1'b0, -1);

    fill_zero();
    vec[0] = 32'h35800000; vec[3] = 32'hB5000000; vec[7] = 32'h34C00000;
    run_model("t5_tiny", 1'b0, -1);
    fill_zero();
    vec[0] = 32'h3FC00000; vec[1] = 32'hBE800000; vec[11] = 32'h3E000000;
    run_model("t5_back_to_back", 1'b0, -1);

    run_model("t6_enable_toggle", 1'b1, -1);
    fill_random();
    run_model("t6_abort", 1'b1, 5);
    stray_idle("t6_after_abort");

    for (int n = 0; n < 8; n++) begin
      fill_random();
      run_model($sformatf("rand%0d", n), n[0], -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
